// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup (IF) and mispredict detection (EX/MEM) are combinational; the table
// and the saturating performance counters update on the rising clock edge.
module branch_predictor #(
   parameter int         ADDR_LEN   = 32,
   parameter int         INDEX_BITS = 4,
   parameter logic [1:0] CNT_INIT   = 2'b01,
   parameter int         STAT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   // lookup port (IF)
   input  logic [ADDR_LEN-1:0]   lookup_pc,
   output logic                  pred_hit,
   output logic                  pred_taken,
   output logic [ADDR_LEN-1:0]   pred_target,
   // update port (resolving stage)
   input  logic                  upd_valid,
   input  logic [ADDR_LEN-1:0]   upd_pc,
   input  logic                  upd_is_branch,
   input  logic                  upd_taken,
   input  logic [ADDR_LEN-1:0]   upd_target,
   input  logic                  upd_pred_taken,
   input  logic [ADDR_LEN-1:0]   upd_pred_target,
   output logic                  mispredict,
   output logic [ADDR_LEN-1:0]   correct_pc,
   // statistics
   input  logic                  stat_clear,
   output logic [STAT_WIDTH-1:0] stat_branches,
   output logic [STAT_WIDTH-1:0] stat_mispredicts
);

   localparam int TAG_BITS = ADDR_LEN - INDEX_BITS - 2;
   localparam int ENTRIES  = 2 ** INDEX_BITS;

   // table state, one slot per index
   logic [ENTRIES-1:0]  r_valid;
   logic [ENTRIES-1:0]  r_is_jump;
   logic [1:0]          r_cnt    [ENTRIES];
   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [ADDR_LEN-1:0] r_target [ENTRIES];

   logic [STAT_WIDTH-1:0] r_stat_br;
   logic [STAT_WIDTH-1:0] r_stat_mp;

   logic [INDEX_BITS-1:0] w_lk_idx;
   logic [TAG_BITS-1:0]   w_lk_tag;
   logic [INDEX_BITS-1:0] w_up_idx;
   logic [TAG_BITS-1:0]   w_up_tag;
   logic                  w_up_hit;
   logic                  w_unused;

   assign w_lk_idx = lookup_pc[INDEX_BITS+1:2];
   assign w_lk_tag = lookup_pc[ADDR_LEN-1:INDEX_BITS+2];
   assign w_up_idx = upd_pc[INDEX_BITS+1:2];
   assign w_up_tag = upd_pc[ADDR_LEN-1:INDEX_BITS+2];
   assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

   // byte offset of the PC never selects anything in the table
   assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

   // lookup: reads registered state only, so a same-cycle update is not bypassed
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path can leave it unassigned and infer a latch.
      pred_hit    = 1'b0;
      pred_taken  = 1'b0;
      pred_target = lookup_pc + ADDR_LEN'(4);
      if (r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag)) begin
         pred_hit   = 1'b1;
         pred_taken = r_is_jump[w_lk_idx] || r_cnt[w_lk_idx][1];
         if (pred_taken) begin
            pred_target = r_target[w_lk_idx];
         end
      end
   end

   // mispredict: wrong direction, or taken to a different target
   always_comb begin
      mispredict = upd_valid &&
                   ((upd_pred_taken != upd_taken) ||
                    (upd_taken && (upd_pred_target != upd_target)));
      correct_pc = upd_taken ? upd_target : (upd_pc + ADDR_LEN'(4));
   end

   // table update: train on a hit, allocate/replace only on a taken miss
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the table is a handful of flops, not a RAM, and every field is
         // cleared so the counters start at a known bias.
         for (int i = 0; i < ENTRIES; i++) begin
            r_cnt[i]    <= CNT_INIT;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
         end
         r_valid   <= '0;
         r_is_jump <= '0;
      end else if (upd_valid) begin
         if (w_up_hit) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge state, independent of statement order.
            if (upd_taken) begin
               if (r_cnt[w_up_idx] != 2'b11) r_cnt[w_up_idx] <= r_cnt[w_up_idx] + 2'd1;
               r_target[w_up_idx] <= upd_target;
            end else if (r_cnt[w_up_idx] != 2'b00) begin
               r_cnt[w_up_idx] <= r_cnt[w_up_idx] - 2'd1;
            end
            r_is_jump[w_up_idx] <= ~upd_is_branch;
         end else if (upd_taken) begin
            r_valid[w_up_idx]   <= 1'b1;
            r_tag[w_up_idx]     <= w_up_tag;
            r_target[w_up_idx]  <= upd_target;
            r_is_jump[w_up_idx] <= ~upd_is_branch;
            r_cnt[w_up_idx]     <= 2'b10;
         end
      end
   end

   // performance counters: saturate at all-ones, clear beats increment
   always_ff @(posedge clk) begin
      if (rst || stat_clear) begin
         r_stat_br <= '0;
         r_stat_mp <= '0;
      end else if (upd_valid) begin
         if (r_stat_br != '1) r_stat_br <= r_stat_br + STAT_WIDTH'(1);
         if (mispredict && (r_stat_mp != '1)) r_stat_mp <= r_stat_mp + STAT_WIDTH'(1);
      end
   end

   assign stat_branches    = r_stat_br;
   assign stat_mispredicts = r_stat_mp;

endmodule
